// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch controller:
//   state_e    - controller states (IDLE, RUN, PAUSE, LAP)
//   DIGIT_MAX9 - upper limit of a decimal digit (c1, c10, s1, m1)
//   DIGIT_MAX5 - upper limit of the tens-of-seconds and tens-of-minutes digits
//   BCD_ZERO   - 00:00:00 display value
// -----------------------------------------------------------------------------
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_e;

   localparam logic [3:0]  DIGIT_MAX9 = 4'd9;
   localparam logic [3:0]  DIGIT_MAX5 = 4'd5;
   localparam logic [23:0] BCD_ZERO   = 24'h000000;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises an asynchronous active-low pushbutton, filters bounces and
// emits a one-cycle pulse on each accepted press (debounced 1->0 edge).
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   key_n   in  raw active-low key, asynchronous to clk
//   pressed out one-cycle pulse per accepted press; releases give nothing
// The debounced level follows the synchronised level only after the two have
// differed for DEB_CYCLES consecutive cycles.
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic pressed
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pressed_q, pressed_d;
   logic          differ, flip;

   // Synchroniser and debounced level reset to "pressed" (0): a key held
   // through reset therefore never looks like a fresh 1->0 edge, and a key
   // that is up simply settles to 1 without producing an event.
   assign differ = (sync2_q != level_q);
   assign flip   = differ && (cnt_q == DEB_LAST);

   always_comb begin
      cnt_d     = '0;
      level_d   = level_q;
      pressed_d = 1'b0;
      if (flip) begin
         level_d   = sync2_q;
         pressed_d = ~sync2_q;
      end else if (differ) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         level_q   <= 1'b0;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
      end else begin
         sync1_q   <= key_n;
         sync2_q   <= sync1_q;
         level_q   <= level_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
      end
   end

   assign pressed = pressed_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Start/stop/lap/clear stopwatch sequencer for the 6-digit seven-segment
// display. A prescaler produces a single-cycle count enable every TICK_DIV
// clocks while counting; the count is kept as BCD MM:SS:CC.
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   key_ss_n   in  start/stop key, active-low, asynchronous
//   key_lap_n  in  lap key, active-low, asynchronous
//   key_clr_n  in  clear key, active-low, asynchronous
//   tick       out one-cycle count enable while counting
//   running    out high in RUN or LAP
//   lap_active out high in LAP
//   disp_bcd   out {m10,m1,s10,s1,c10,c1}, registered; lap value in LAP
//   state_dbg  out current controller state (state_e encoding)
// -----------------------------------------------------------------------------
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 500_000,
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_ss_n,
   input  logic        key_lap_n,
   input  logic        key_clr_n,
   output logic        tick,
   output logic        running,
   output logic        lap_active,
   output logic [23:0] disp_bcd,
   output logic [1:0]  state_dbg
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_e        state_q, state_d;
   logic [23:0]   count_q, count_d;
   logic [23:0]   lap_q, lap_d;
   logic [23:0]   disp_q, disp_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          ss_ev, lap_ev, clr_ev;
   logic          ss_act, lap_act;
   logic          advancing, tick_w;

   // Digit 0 is c1; digits 3 (s10) and 5 (m10) roll over at 5, the rest at 9.
   // Using >= on the limit keeps any digit from leaving its legal range.
   function automatic logic [23:0] bcd_inc(input logic [23:0] v);
      logic [23:0] r;
      logic        carry;
      logic [3:0]  lim;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lim = ((i == 3) || (i == 5)) ? DIGIT_MAX5 : DIGIT_MAX9;
         if (carry) begin
            if (r[i*4 +: 4] >= lim) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
      .clk(clk), .rst_n(rst_n), .key_n(key_ss_n), .pressed(ss_ev)
   );
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
      .clk(clk), .rst_n(rst_n), .key_n(key_lap_n), .pressed(lap_ev)
   );
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
      .clk(clk), .rst_n(rst_n), .key_n(key_clr_n), .pressed(clr_ev)
   );

   // Only the highest-priority event of a cycle survives (clr > ss > lap),
   // even when the winner is ignored in the current state.
   assign ss_act  = ss_ev & ~clr_ev;
   assign lap_act = lap_ev & ~clr_ev & ~ss_ev;

   assign advancing = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign tick_w    = advancing && (presc_q == PRESC_LAST);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lap_d   = lap_q;
      presc_d = presc_q;

      if (advancing) begin
         presc_d = tick_w ? '0 : presc_q + PW'(1);
      end else if (state_q == ST_IDLE) begin
         presc_d = '0;
      end

      if (tick_w) begin
         count_d = bcd_inc(count_q);
      end

      case (state_q)
         ST_IDLE: begin
            if (ss_act) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ss_act) begin
               state_d = ST_PAUSE;
            end else if (lap_act) begin
               state_d = ST_LAP;
               lap_d   = count_d;  // includes an increment landing this cycle
            end
         end
         ST_LAP: begin
            if (ss_act) begin
               state_d = ST_PAUSE;
            end else if (lap_act) begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (clr_ev) begin
               state_d = ST_IDLE;
               count_d = BCD_ZERO;
            end else if (ss_act) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Display register tracks the next-state source so it shows the new
      // value one cycle after the update that produced it.
      disp_d = (state_d == ST_LAP) ? lap_d : count_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= BCD_ZERO;
         lap_q   <= BCD_ZERO;
         disp_q  <= BCD_ZERO;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lap_q   <= lap_d;
         disp_q  <= disp_d;
         presc_q <= presc_d;
      end
   end

   assign tick       = tick_w;
   assign running    = advancing;
   assign lap_active = (state_q == ST_LAP);
   assign disp_bcd   = disp_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        key_ss_n = 1'b1;
  logic        key_lap_n = 1'b1;
  logic        key_clr_n = 1'b1;
  logic        tick;
  logic        running;
  logic        lap_active;
  logic [23:0] disp_bcd;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  int tick_cnt = 0;
  int run_cnt  = 0;
  int last_gap = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_ss_n(key_ss_n), .key_lap_n(key_lap_n), .key_clr_n(key_clr_n),
    .tick(tick), .running(running), .lap_active(lap_active),
    .disp_bcd(disp_bcd), .state_dbg(state_dbg)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers ----------------
  // One cycle; tracks ticks seen and the number of running cycles between
  // consecutive ticks (including the tick cycle itself).
  task automatic step();
    @(negedge clk);
    if (running === 1'b1) run_cnt++;
    if (tick === 1'b1) begin
      last_gap = run_cnt;
      run_cnt  = 0;
      tick_cnt++;
    end
  endtask

  function automatic logic [23:0] to_bcd(input int n);
    int c, s, m;
    n = n % 360000;
    c = n % 100;
    s = (n / 100) % 60;
    m = (n / 6000) % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // Display value while live: ticks of earlier cycles.
  function automatic logic [23:0] exp_live();
    return to_bcd(tick_cnt - ((tick === 1'b1) ? 1 : 0));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    key_ss_n = 1'b1; key_lap_n = 1'b1; key_clr_n = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (DEB + 6) step();
    tick_cnt = 0; run_cnt = 0; last_gap = 0;
  endtask

  task automatic press(input bit ss, input bit lap, input bit clr, input int hold);
    if (ss)  key_ss_n  = 1'b0;
    if (lap) key_lap_n = 1'b0;
    if (clr) key_clr_n = 1'b0;
    repeat (hold) step();
    key_ss_n = 1'b1; key_lap_n = 1'b1; key_clr_n = 1'b1;
  endtask

  task automatic wait_ticks(input int target);
    int g = 0;
    while (tick_cnt < target && g < 3000) begin
      step();
      g++;
    end
    n_checks++;
    if (tick_cnt < target) begin
      n_err++;
      $display("FAIL wait_ticks: got %0d ticks want %0d", tick_cnt, target);
    end
  endtask

  task automatic wait_run(input logic v);
    int g = 0;
    while (running !== v && g < 40) begin
      step();
      g++;
    end
    n_checks++;
    if (running !== v) begin
      n_err++;
      $display("FAIL wait_run: got %b want %b", running, v);
    end
  endtask

  task automatic wait_lap(input logic v);
    int g = 0;
    while (lap_active !== v && g < 40) begin
      step();
      g++;
    end
    n_checks++;
    if (lap_active !== v) begin
      n_err++;
      $display("FAIL wait_lap: got %b want %b", lap_active, v);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (disp_bcd !== 24'h000000) begin n_err++; $display("FAIL reset_disp: got %h want 000000", disp_bcd); end
    n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
    n_checks++; if (lap_active !== 1'b0) begin n_err++; $display("FAIL reset_lap: got %b want 0", lap_active); end
    n_checks++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_checks++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    do_reset();
  endtask

  task automatic test_start();
    do_reset();
    key_ss_n = 1'b0;
    for (int i = 0; i < 60 && tick_cnt < 1; i++) begin
      step();
      if (i == 9) key_ss_n = 1'b1;
    end
    key_ss_n = 1'b1;
    n_checks++; if (tick_cnt !== 1) begin n_err++; $display("FAIL start_tick_seen: got %0d want 1", tick_cnt); end
    n_checks++; if (last_gap !== TICK_DIV) begin n_err++; $display("FAIL start_latency: got %0d want %0d", last_gap, TICK_DIV); end
    n_checks++; if (running !== 1'b1) begin n_err++; $display("FAIL start_running: got %b want 1", running); end
    step();
    n_checks++; if (disp_bcd !== 24'h000001) begin n_err++; $display("FAIL start_first_count: got %h want 000001", disp_bcd); end
    repeat (15) step();
    n_checks++; if (running !== 1'b1 || lap_active !== 1'b0) begin n_err++; $display("FAIL start_single_event: got run=%b lap=%b want 1 0", running, lap_active); end
    n_checks++; if (disp_bcd !== exp_live()) begin n_err++; $display("FAIL start_live: got %h want %h", disp_bcd, exp_live()); end
  endtask

  task automatic test_lap();
    do_reset();
    press(1, 0, 0, 6);
    wait_ticks(37);
    step();
    n_checks++; if (disp_bcd !== 24'h000037) begin n_err++; $display("FAIL lap_pre: got %h want 000037", disp_bcd); end
    press(0, 1, 0, 6);
    wait_lap(1);
    n_checks++; if (disp_bcd !== 24'h000037) begin n_err++; $display("FAIL lap_frozen: got %h want 000037", disp_bcd); end
    wait_ticks(45);
    step();
    n_checks++; if (disp_bcd !== 24'h000037) begin n_err++; $display("FAIL lap_held: got %h want 000037", disp_bcd); end
    n_checks++; if (running !== 1'b1 || lap_active !== 1'b1) begin n_err++; $display("FAIL lap_state: got run=%b lap=%b want 1 1", running, lap_active); end
    // 3-cycle glitch must be filtered out
    key_lap_n = 1'b0;
    repeat (DEB - 1) step();
    key_lap_n = 1'b1;
    repeat (15) step();
    n_checks++; if (lap_active !== 1'b1) begin n_err++; $display("FAIL lap_glitch: got %b want 1", lap_active); end
    // exactly DEB cycles low is accepted
    press(0, 1, 0, DEB);
    wait_lap(0);
    n_checks++; if (disp_bcd !== exp_live()) begin n_err++; $display("FAIL lap_live: got %h want %h", disp_bcd, exp_live()); end
    n_checks++; if (running !== 1'b1) begin n_err++; $display("FAIL lap_exit_running: got %b want 1", running); end
  endtask

  task automatic test_pause_clear();
    int tc;
    do_reset();
    press(1, 0, 0, 6);
    wait_ticks(2);
    press(0, 0, 1, 6);
    repeat (10) step();
    n_checks++; if (running !== 1'b1) begin n_err++; $display("FAIL clr_in_run: got %b want 1", running); end
    n_checks++; if (disp_bcd !== exp_live()) begin n_err++; $display("FAIL clr_in_run_disp: got %h want %h", disp_bcd, exp_live()); end
    wait_ticks(tick_cnt + 1);
    press(1, 0, 0, 6);
    wait_run(0);
    tc = tick_cnt;
    repeat (100) step();
    n_checks++; if (tick_cnt !== tc) begin n_err++; $display("FAIL pause_no_tick: got %0d want %0d", tick_cnt, tc); end
    n_checks++; if (disp_bcd !== to_bcd(tc)) begin n_err++; $display("FAIL pause_hold: got %h want %h", disp_bcd, to_bcd(tc)); end
    press(1, 0, 0, 6);
    wait_ticks(tc + 1);
    n_checks++; if (last_gap !== TICK_DIV) begin n_err++; $display("FAIL resume_gap: got %0d want %0d", last_gap, TICK_DIV); end
    step();
    n_checks++; if (disp_bcd !== to_bcd(tc + 1)) begin n_err++; $display("FAIL resume_count: got %h want %h", disp_bcd, to_bcd(tc + 1)); end
    press(1, 0, 0, 6);
    wait_run(0);
    repeat (12) step();
    press(0, 0, 1, 6);
    repeat (10) step();
    n_checks++; if (state_dbg !== 2'd0 || running !== 1'b0) begin n_err++; $display("FAIL clr_in_pause: got state=%0d run=%b want 0 0", state_dbg, running); end
    n_checks++; if (disp_bcd !== 24'h000000) begin n_err++; $display("FAIL clr_disp: got %h want 000000", disp_bcd); end
  endtask

  task automatic test_clr_ss_same_cycle();
    do_reset();
    press(1, 0, 0, 6);
    wait_ticks(1);
    press(1, 0, 0, 6);
    wait_run(0);
    repeat (12) step();
    press(1, 0, 1, 6);
    repeat (20) step();
    n_checks++; if (state_dbg !== 2'd0 || running !== 1'b0) begin n_err++; $display("FAIL clr_wins: got state=%0d run=%b want 0 0", state_dbg, running); end
    n_checks++; if (disp_bcd !== 24'h000000) begin n_err++; $display("FAIL clr_wins_disp: got %h want 000000", disp_bcd); end
  endtask

  task automatic test_rollover();
    do_reset();
    force dut.count_q = 24'h005999;
    step();
    release dut.count_q;
    step();
    n_checks++; if (disp_bcd !== 24'h005999) begin n_err++; $display("FAIL roll_preload: got %h want 005999", disp_bcd); end
    press(1, 0, 0, 6);
    wait_ticks(1);
    step();
    n_checks++; if (disp_bcd !== 24'h010000) begin n_err++; $display("FAIL roll_minute: got %h want 010000", disp_bcd); end
    do_reset();
    force dut.count_q = 24'h595999;
    step();
    release dut.count_q;
    step();
    press(1, 0, 0, 6);
    wait_ticks(1);
    step();
    n_checks++; if (disp_bcd !== 24'h000000) begin n_err++; $display("FAIL roll_wrap: got %h want 000000", disp_bcd); end
    n_checks++; if (running !== 1'b1) begin n_err++; $display("FAIL roll_wrap_running: got %b want 1", running); end
    wait_ticks(2);
    step();
    n_checks++; if (disp_bcd !== 24'h000001) begin n_err++; $display("FAIL roll_continue: got %h want 000001", disp_bcd); end
  endtask

  task automatic test_async_reset();
    do_reset();
    press(1, 0, 0, 6);
    wait_ticks(3);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (disp_bcd !== 24'h000000) begin n_err++; $display("FAIL areset_disp: got %h want 000000", disp_bcd); end
    n_checks++; if (running !== 1'b0 || lap_active !== 1'b0 || tick !== 1'b0) begin n_err++; $display("FAIL areset_flags: got run=%b lap=%b tick=%b want 0 0 0", running, lap_active, tick); end
    // key held through reset must not produce an event
    key_ss_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();
    n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL held_key_reset: got %b want 0", running); end
    key_ss_n = 1'b1;
    repeat (12) step();
    press(1, 0, 0, 6);
    wait_run(1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_clear();
    test_clr_ss_same_cycle();
    test_rollover();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences the 6-digit display counter as a stopwatch for the DE2 seven-segment board. It debounces three pushbuttons and runs a start/stop/lap/clear state machine. It generates the 10 ms count enable as a single-cycle clock-enable, not a derived clock. It outputs a 24-bit BCD MM:SS:CC value that feeds the seg7 decoders directly.

Parameters:
TICK_DIV, 500_000, clk cycles per 10 ms count step (50 MHz clk)
DEB_CYCLES, 1_000_000, cycles a key level must hold stable before it is accepted (20 ms)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
key_ss_n  in  1  start/stop key, active-low, asynchronous to clk
key_lap_n  in  1  lap key, active-low, asynchronous
key_clr_n  in  1  clear key, active-low, asynchronous
tick  out  1  one-cycle pulse every TICK_DIV cycles while counting
running  out  1  high in RUN or LAP
lap_active  out  1  high in LAP
disp_bcd  out  24  {m10,m1,s10,s1,c10,c1}, 4-bit BCD each

Behaviour:
- Reset is asynchronous on rst_n; clock is clk.
- Reset values:
  - state IDLE; count, lap_reg, prescaler and debounce counters all 0.
  - tick=0, running=0, lap_active=0, disp_bcd=24'h000000.
- Key path, per key:
  - 2-FF synchronizer, then a stable-level counter.
  - The debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles.
  - A press event is a one-cycle pulse on a debounced 1->0 transition.
  - Key release generates no event. Bounces shorter than DEB_CYCLES generate nothing.
- Event priority within one cycle: clr > ss > lap. Only the highest-priority event is acted on; the others are dropped.
- FSM, where the transition takes effect in the cycle after the event pulse:
  - IDLE: ss -> RUN, prescaler cleared to 0. lap and clr ignored.
  - RUN: ss -> PAUSE. lap -> LAP, with lap_reg <= count, including any increment landing in the same cycle. clr ignored.
  - LAP: lap -> RUN (display goes live). ss -> PAUSE (display goes live). clr ignored.
  - PAUSE: ss -> RUN, prescaler keeps its value. clr -> IDLE, count <= 0. lap ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - Advances only in RUN/LAP; holds in PAUSE; held at 0 in IDLE.
  - tick=1 in the cycle the prescaler equals TICK_DIV-1 while advancing.
- Count update, on tick:
  - BCD increment with carries: c1 9->0 carries to c10; c10 9->0 carries to s1; s1 9->0 to s10; s10 5->0 to m1; m1 9->0 to m10; m10 5->0.
  - 59:59:99 wraps to 00:00:00 and counting continues.
  - No digit ever holds a non-BCD value or exceeds its limit (s10 and m10 max 5).
- disp_bcd is lap_reg in LAP, otherwise count. It is a registered output and updates the cycle after the source changes.
- Latency: from the IDLE->RUN transition, the first increment occurs after exactly TICK_DIV cycles, then every TICK_DIV cycles.
- Reset mid-count returns everything to reset values immediately. The keys need a fresh debounced press afterwards; a key held through reset does not produce an event until it is released and pressed again.

Decomposition:
- Package stopwatch_pkg:
  - state encoding (IDLE, RUN, PAUSE, LAP)
  - BCD digit limits (9, 5)
  - zero value 24'h000000
- Sub-module key_debounce, parameter DEB_CYCLES:
  - ports clk, rst_n, key_n, pressed (pulse)
  - instantiated three times
- BCD increment stays inline as a combinational function.

Test Plan:
(all with TICK_DIV=10, DEB_CYCLES=4)
- Reset then single ss press held 10 cycles -> one event; running=1; first tick 10 cycles after RUN entry; disp_bcd=000001 one cycle later.
- Glitch on key_lap_n low for 3 cycles -> no event, state unchanged. Low for 4+ cycles -> exactly one event.
- Run from 00:59:99 (force count) -> next tick gives 01:00:00. Run from 59:59:99 -> next tick gives 00:00:00 and running stays 1.
- RUN at 00:00:37, lap press -> disp_bcd frozen at 000037 while count advances to 000045. Second lap press -> disp_bcd shows live count.
- RUN, ss -> PAUSE: count and prescaler hold for 100 cycles. ss -> RUN: next tick arrives after the remaining prescaler cycles. clr in RUN ignored; clr in PAUSE -> IDLE, disp_bcd=000000.
- clr and ss events in the same cycle while in PAUSE -> IDLE (clr wins). Assert rst_n mid-RUN -> all outputs 0 asynchronously.
